// File: rtl/spi_slave_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_ctrl_pkg
//  Description : Shared types and constants for the SPI slave frame controller
//                (FSM state enum, command byte layout, bus widths, address
//                step helper honouring SPI_SLAVE_CTRL_AUTOINC_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_ctrl_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CMD_RW_BIT = 7;
    localparam int CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR      = 3'd2,
        RD_REQ  = 3'd3,
        RD_CAP  = 3'd4,
        RD_WAIT = 3'd5
    } state_t;

    // Address to use after a completed bus access: next register when
    // auto-increment is built in, otherwise the same (FIFO-style) register.
    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] addr);
`ifdef SPI_SLAVE_CTRL_AUTOINC_EN
        return addr + ADDR_W'(1);
`else
        return addr;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_ctrl_if
//  Description : Byte-port and register-bus signals of the SPI slave frame
//                controller. The slave modport is the controller's view, the
//                master modport is the view of the shifter / register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_ctrl_if;
    import spi_slave_ctrl_pkg::*;

    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_wr;
    logic              bus_rd;
    logic [DATA_W-1:0] bus_rdata;
    logic              busy;
    logic              err;

    modport slave (
        input  rx_valid, rx_data, bus_rdata,
        output tx_data, tx_load, bus_addr, bus_wdata, bus_wr, bus_rd, busy, err
    );

    modport master (
        output rx_valid, rx_data, bus_rdata,
        input  tx_data, tx_load, bus_addr, bus_wdata, bus_wr, bus_rd, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/spi_slave_ctrl_ss_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ss_edge
//  Description : Two-flop synchronizer for the raw SPI chip select plus a
//                previous-value register; emits ss_fall / ss_rise pulses and
//                the synchronized level. Resets to deselected (1).
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ss_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic ena,
    input  wire logic spi_ss,
    output logic      ss_fall,
    output logic      ss_rise,
    output logic      ss_level
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [2:0] r_fill;

    // Synchronize the pin, remember the previous synchronized level, and track
    // when the pipeline holds only real pin samples. Edges stay suppressed until
    // then so a frame already in progress at reset release is not taken as new.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_fill  <= 3'b000;
        end else if (ena) begin
            r_sync1 <= spi_ss;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[1:0], 1'b1};
        end
    end

    assign ss_fall  = r_fill[2] &  r_prev & ~r_sync2;
    assign ss_rise  = r_fill[2] & ~r_prev &  r_sync2;
    assign ss_level = r_sync2;

endmodule
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_ctrl
//  Description : SPI slave frame controller. Decodes the first byte of each
//                chip-select frame as a read/write command with 7-bit start
//                address and sequences register-bus writes or prefetched reads.
//                Build option: SPI_SLAVE_CTRL_AUTOINC_EN enables bus_addr
//                auto-increment (mod 128) after each write and read capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_ctrl
    import spi_slave_ctrl_pkg::*;
#(
    parameter int          BURST_MAX = 16,
    parameter logic [7:0]  TX_IDLE   = 8'hFF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           ena,
    input  wire logic           spi_ss,
    spi_slave_ctrl_if.slave     bus
);

    localparam logic [CNT_W-1:0] c_burst_max = CNT_W'(BURST_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_count_inc;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_wr;
    logic              w_wr_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] w_tx_data_nxt;
    logic              r_abort_load;
    logic              w_abort_load_nxt;

    logic              w_ss_fall;
    logic              w_ss_rise;
    logic              w_ss_level;
    logic              w_rx;
    logic              w_room;
    logic              w_cap;

    spi_ss_edge u_ss_edge (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .spi_ss   (spi_ss),
        .ss_fall  (w_ss_fall),
        .ss_rise  (w_ss_rise),
        .ss_level (w_ss_level)
    );

    // A byte only counts while the synchronized select is low: in the cycle the
    // rising edge is seen the abort wins and that byte is discarded.
    assign w_rx        = bus.rx_valid & ~w_ss_level;
    assign w_room      = (r_count < c_burst_max);
    assign w_count_inc = r_count + CNT_W'(1);

    // Next-state and datapath decode for the frame sequencer.
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_wr_nxt         = 1'b0;
        w_err_nxt        = r_err;
        w_tx_data_nxt    = r_tx_data;
        w_abort_load_nxt = 1'b0;

        // The write strobe is on the bus this cycle; advance past it.
        if (r_wr) begin
            w_addr_nxt = addr_step(r_addr);
        end

        if (w_ss_rise && (r_state != IDLE)) begin
            w_state_nxt      = IDLE;
            w_tx_data_nxt    = TX_IDLE;
            w_abort_load_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        w_state_nxt = CMD;
                        w_count_nxt = '0;
                        w_err_nxt   = 1'b0;
                    end
                end
                CMD: begin
                    if (w_rx) begin
                        w_addr_nxt  = bus.rx_data[ADDR_W-1:0];
                        w_state_nxt = bus.rx_data[CMD_RW_BIT] ? RD_REQ : WR;
                    end
                end
                WR: begin
                    if (w_rx) begin
                        if (w_room) begin
                            w_wdata_nxt = bus.rx_data;
                            w_wr_nxt    = 1'b1;
                            w_count_nxt = w_count_inc;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                RD_REQ, RD_CAP: begin
                    if (r_state == RD_REQ) begin
                        w_state_nxt = RD_CAP;
                    end else begin
                        w_tx_data_nxt = bus.bus_rdata;
                        w_addr_nxt    = addr_step(r_addr);
                        w_state_nxt   = RD_WAIT;
                    end
                    if (w_rx) begin
                        if (w_room) begin
                            w_count_nxt = w_count_inc;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (w_rx) begin
                        if (w_room) begin
                            w_count_nxt = w_count_inc;
                            // No prefetch once the last byte of the burst is out.
                            if (w_count_inc < c_burst_max) begin
                                w_state_nxt = RD_REQ;
                            end
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; everything holds while the clock enable is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wr         <= 1'b0;
            r_err        <= 1'b0;
            r_tx_data    <= TX_IDLE;
            r_abort_load <= 1'b0;
        end else if (ena) begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wr         <= w_wr_nxt;
            r_err        <= w_err_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_abort_load <= w_abort_load_nxt;
        end
    end

    // Read data is forwarded in the capture cycle so tx_load and the new byte
    // appear together two cycles after the command; it is registered as it passes.
    assign w_cap         = (r_state == RD_CAP);
    assign bus.tx_data   = w_cap ? bus.bus_rdata : r_tx_data;
    assign bus.tx_load   = ena & (w_cap | r_abort_load);
    assign bus.bus_rd    = ena & (r_state == RD_REQ);
    assign bus.bus_wr    = ena & r_wr;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign bus.busy      = (r_state != IDLE);
    assign bus.err       = r_err;

endmodule
`default_nettype wire
